// File: rtl/iterative_square.sv
// Iterative unsigned squarer: a HALF-bit root is squared by shift-add over HALF
// cycles, with val/rdy handshakes on the operand and result sides.
module iterative_square #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BIT_WIDTH/2-1:0] recv_msg,
  input  logic                   recv_val,
  output logic                   recv_rdy,
  output logic [BIT_WIDTH-1:0]   send_msg,
  output logic                   send_val,
  input  logic                   send_rdy
);

  localparam int HALF = BIT_WIDTH / 2;
  localparam int CW   = $clog2(HALF) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [BIT_WIDTH-1:0] r_acc;
  logic [BIT_WIDTH-1:0] r_mcand;
  logic [HALF-1:0]      r_mplier;
  logic [CW-1:0]        r_counter;
  logic                 r_recv_rdy;
  logic                 r_send_val;

  logic                 w_accept;
  logic                 w_release;
  logic [BIT_WIDTH-1:0] w_sum;

  assign w_accept  = recv_val && r_recv_rdy;
  assign w_release = r_send_val && send_rdy;
  assign w_sum     = r_acc + r_mcand;

  assign recv_rdy = r_recv_rdy;
  assign send_val = r_send_val;
  assign send_msg = r_acc;

  // NOTE: every flop here uses <= so all registers see the pre-edge values of
  // each other, which is what makes the shift and the add line up per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_counter  <= '0;
      r_recv_rdy <= 1'b1;
      r_send_val <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand    <= {{HALF{1'b0}}, recv_msg};
            r_mplier   <= recv_msg;
            r_acc      <= '0;
            r_counter  <= CW'(HALF);
            r_state    <= S_CALC;
            r_recv_rdy <= 1'b0;
          end
        end
        S_CALC: begin
          if (r_mplier[0]) begin
            r_acc <= w_sum;
          end
          r_mcand   <= r_mcand << 1;
          r_mplier  <= r_mplier >> 1;
          r_counter <= r_counter - 1'b1;
          // Fixed HALF-cycle latency: no early exit once the multiplier empties.
          if (r_counter == CW'(1)) begin
            r_state    <= S_DONE;
            r_send_val <= 1'b1;
          end
        end
        S_DONE: begin
          if (w_release) begin
            r_state    <= S_IDLE;
            r_send_val <= 1'b0;
            r_recv_rdy <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_send_val <= 1'b0;
          r_recv_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_square.sv
// Self-checking bench for iterative_square: directed corner cases, backpressure,
// mid-calculation reset and a randomized round trip through a reference sqrt.
module tb_iterative_square;

  localparam int BW   = 32;
  localparam int HALF = BW / 2;
  localparam int LAT  = HALF;

  logic            clk;
  logic            reset;
  logic [HALF-1:0] recv_msg;
  logic            recv_val;
  logic            recv_rdy;
  logic [BW-1:0]   send_msg;
  logic            send_val;
  logic            send_rdy;

  int n_cmp;
  int n_mis;

  iterative_square #(.BIT_WIDTH(BW)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic square and integer square root.
  function automatic logic [BW-1:0] ref_square(input logic [HALF-1:0] r);
    longint unsigned v;
    v = longint'(r) * longint'(r);
    return v[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] ref_isqrt(input logic [BW-1:0] v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'd65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid;
    end
    return lo[BW-1:0];
  endfunction

  // Present an operand, wait for acceptance, then return at the first negedge after.
  task automatic offer(input logic [HALF-1:0] op);
    int n;
    recv_msg = op;
    recv_val = 1'b1;
    n = 0;
    while (!recv_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_rdy", {31'd0, recv_rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    recv_val = 1'b0;
    recv_msg = HALF'($urandom);
  endtask

  // Count cycles from the accepting edge until send_val is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!send_val && lat < 4 * LAT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic transact(input logic [HALF-1:0] op, input int pre, input int stall,
                          input bit poke_recv);
    int lat;
    logic [BW-1:0] exp;
    exp = ref_square(op);
    send_rdy = 1'b0;
    repeat (pre) @(negedge clk);
    offer(op);
    wait_result(lat);
    check("latency", lat, LAT);
    check("result", send_msg, exp);
    check("round_trip", ref_isqrt(send_msg), {16'd0, op});
    for (int i = 0; i < stall; i++) begin
      if (poke_recv) begin
        recv_val = 1'b1;
        recv_msg = op ^ 16'h5A5A;
      end
      @(negedge clk);
      check("stall_val", {31'd0, send_val}, 32'd1);
      check("stall_msg", send_msg, exp);
      check("stall_rdy", {31'd0, recv_rdy}, 32'd0);
    end
    recv_val = 1'b0;
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
    check("post_val", {31'd0, send_val}, 32'd0);
    check("post_rdy", {31'd0, recv_rdy}, 32'd1);
    if (poke_recv) check("post_hold", send_msg, exp);
  endtask

  initial begin
    int lat;
    n_cmp    = 0;
    n_mis    = 0;
    reset    = 1'b0;
    recv_msg = '0;
    recv_val = 1'b0;
    send_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy", {31'd0, recv_rdy}, 32'd1);
    check("rst_val", {31'd0, send_val}, 32'd0);
    check("rst_msg", send_msg, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_rdy", {31'd0, recv_rdy}, 32'd1);
    check("idle_val", {31'd0, send_val}, 32'd0);
    check("idle_msg", send_msg, 32'd0);

    transact(16'h0000, 0, 0, 1'b0);
    transact(16'h0003, 1, 0, 1'b0);
    transact(16'h1234, 0, 1, 1'b0);
    transact(16'hFFFF, 0, 0, 1'b0);
    check("k_1234", ref_square(16'h1234), 32'h014B5A90);
    check("k_ffff", ref_square(16'hFFFF), 32'hFFFE0001);

    // Backpressure with a competing operand on the receive side.
    transact(16'h00A5, 0, 5, 1'b1);

    // Reset in the middle of a calculation.
    offer(16'h00FF);
    repeat (7) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_val", {31'd0, send_val}, 32'd0);
    check("mid_rst_rdy", {31'd0, recv_rdy}, 32'd1);
    check("mid_rst_msg", send_msg, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("after_rst_val", {31'd0, send_val}, 32'd0);
    transact(16'h0007, 0, 0, 1'b0);

    // Reset while holding a result in DONE.
    offer(16'h0101);
    wait_result(lat);
    check("done_val", {31'd0, send_val}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("done_rst_val", {31'd0, send_val}, 32'd0);
    check("done_rst_msg", send_msg, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      logic [HALF-1:0] r;
      r = (i < 4) ? HALF'(i) : HALF'($urandom);
      transact(r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
